// File: rtl/ofmap_writeback.sv
// rtl/ofmap_writeback.sv - requantise, clamp and pack GEMM partial sums into the mem2 output BRAM
// Stage 1 rounds and shifts each lane; stage 2 clamps, packs and issues the write.
module ofmap_writeback #(
  parameter int LANES      = 14,
  parameter int PSUM_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int AWIDTH     = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [AWIDTH-1:0]           num_words_i,
  input  logic                        relu_en_i,
  input  logic [4:0]                  shift_i,
  input  logic                        psum_valid_i,
  input  logic [LANES*PSUM_WIDTH-1:0] psum_i,
  output logic                        ready_o,
  output logic [AWIDTH-1:0]           mem2_addr_o,
  output logic                        mem2_ce_o,
  output logic                        mem2_we_o,
  output logic [LANES*DATA_WIDTH-1:0] mem2_d_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int EW = PSUM_WIDTH + 1;
  localparam logic [AWIDTH-1:0]    A_ONE = AWIDTH'(1);
  localparam logic signed [EW-1:0] U_MAX = EW'((1 << DATA_WIDTH) - 1);
  localparam logic signed [EW-1:0] S_MAX = EW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] S_MIN = EW'(-(1 << (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [AWIDTH-1:0]    cfg_num_words;
  logic                 cfg_relu;
  logic [4:0]           cfg_shift;
  logic [AWIDTH-1:0]    beat_cnt;
  logic [AWIDTH-1:0]    wr_cnt;
  logic                 s1_valid;
  logic signed [EW-1:0] s1_lane [LANES];

  logic                 accept;
  logic                 last_beat;
  logic signed [EW-1:0] rnd;
  logic signed [EW-1:0] lane_sum [LANES];
  logic signed [EW-1:0] lane_shr [LANES];
  logic [LANES*DATA_WIDTH-1:0] pack_d;

  assign accept    = psum_valid_i & ready_o;
  assign last_beat = (beat_cnt + A_ONE) == cfg_num_words;

  // Rounding constant is half an LSB of the shifted result; zero when no shift.
  always_comb begin
    rnd = '0;
    if (cfg_shift != 5'd0) rnd = EW'(1) << (cfg_shift - 5'd1);
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_sum[i] = {psum_i[(LANES-1-i)*PSUM_WIDTH + PSUM_WIDTH - 1],
                     psum_i[(LANES-1-i)*PSUM_WIDTH +: PSUM_WIDTH]} + rnd;
      lane_shr[i] = lane_sum[i] >>> cfg_shift;
    end
  end

  always_comb begin
    pack_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cfg_relu) begin
        if (s1_lane[i][EW-1])
          pack_d[(LANES-1-i)*DATA_WIDTH +: DATA_WIDTH] = '0;
        else if (s1_lane[i] > U_MAX)
          pack_d[(LANES-1-i)*DATA_WIDTH +: DATA_WIDTH] = '1;
        else
          pack_d[(LANES-1-i)*DATA_WIDTH +: DATA_WIDTH] = s1_lane[i][DATA_WIDTH-1:0];
      end else begin
        if (s1_lane[i] < S_MIN)
          pack_d[(LANES-1-i)*DATA_WIDTH +: DATA_WIDTH] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else if (s1_lane[i] > S_MAX)
          pack_d[(LANES-1-i)*DATA_WIDTH +: DATA_WIDTH] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else
          pack_d[(LANES-1-i)*DATA_WIDTH +: DATA_WIDTH] = s1_lane[i][DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cfg_num_words <= '0;
      cfg_relu      <= 1'b0;
      cfg_shift     <= '0;
      beat_cnt      <= '0;
      wr_cnt        <= '0;
      s1_valid      <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_lane[i] <= '0;
      ready_o       <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      mem2_ce_o     <= 1'b0;
      mem2_we_o     <= 1'b0;
      mem2_addr_o   <= '0;
      mem2_d_o      <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        for (int i = 0; i < LANES; i++) s1_lane[i] <= lane_shr[i];
      end

      // Address and data hold their last values through gaps.
      mem2_ce_o <= s1_valid;
      mem2_we_o <= s1_valid;
      if (s1_valid) begin
        mem2_addr_o <= wr_cnt;
        mem2_d_o    <= pack_d;
        wr_cnt      <= wr_cnt + A_ONE;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            cfg_num_words <= num_words_i;
            cfg_relu      <= relu_en_i;
            cfg_shift     <= shift_i;
            beat_cnt      <= '0;
            wr_cnt        <= '0;
            busy_o        <= 1'b1;
            if (num_words_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state   <= RUN;
              ready_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            beat_cnt <= beat_cnt + A_ONE;
            if (last_beat) begin
              state   <= DRAIN;
              ready_o <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // wr_cnt reaches num_words only in the cycle the final write is on the port.
          if (mem2_ce_o && (wr_cnt == cfg_num_words)) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b0;
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_writeback.sv
// tb/tb_ofmap_writeback.sv - scoreboard bench for ofmap_writeback
// Stimulus pushes expected writes; a negedge monitor pops and compares them.
module tb_ofmap_writeback;

  localparam int LANES = 14;
  localparam int PW    = 32;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int PSW   = LANES * PW;
  localparam int DSW   = LANES * DW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_i = 1'b0;
  logic [AW-1:0]  num_words_i = '0;
  logic           relu_en_i = 1'b0;
  logic [4:0]     shift_i = '0;
  logic           psum_valid_i = 1'b0;
  logic [PSW-1:0] psum_i = '0;
  logic           ready_o;
  logic [AW-1:0]  mem2_addr_o;
  logic           mem2_ce_o;
  logic           mem2_we_o;
  logic [DSW-1:0] mem2_d_o;
  logic           busy_o;
  logic           done_o;

  always #5 clk = ~clk;

  ofmap_writeback #(.LANES(LANES), .PSUM_WIDTH(PW), .DATA_WIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_words_i(num_words_i),
    .relu_en_i(relu_en_i), .shift_i(shift_i), .psum_valid_i(psum_valid_i), .psum_i(psum_i),
    .ready_o(ready_o), .mem2_addr_o(mem2_addr_o), .mem2_ce_o(mem2_ce_o), .mem2_we_o(mem2_we_o),
    .mem2_d_o(mem2_d_o), .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct {
    logic [AW-1:0]  addr;
    logic [DSW-1:0] data;
    int             cyc;
  } exp_t;

  exp_t           exp_q[$];
  exp_t           me;
  int             checks = 0;
  int             failures = 0;
  int             cyc = 0;
  int             wr_count = 0;
  int             last_wr_cyc = -1;
  logic [AW-1:0]  last_addr = '0;
  logic [DSW-1:0] last_d = '0;
  logic [AW-1:0]  nxt_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_addr = '0;
      last_d    = '0;
    end else begin
      checks++;
      if (mem2_ce_o !== mem2_we_o) begin
        failures++;
        $display("FAIL ce_eq_we ce=%b we=%b cyc=%0d", mem2_ce_o, mem2_we_o, cyc);
      end
      checks++;
      if (mem2_ce_o === 1'b1) begin
        wr_count++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write addr=%0d d=%h cyc=%0d", mem2_addr_o, mem2_d_o, cyc);
        end else begin
          me = exp_q.pop_front();
          if (mem2_addr_o !== me.addr || mem2_d_o !== me.data || cyc != me.cyc) begin
            failures++;
            $display("FAIL write got addr=%0d d=%h cyc=%0d want addr=%0d d=%h cyc=%0d",
                     mem2_addr_o, mem2_d_o, cyc, me.addr, me.data, me.cyc);
          end
        end
        last_addr = mem2_addr_o;
        last_d    = mem2_d_o;
      end else if (mem2_addr_o !== last_addr || mem2_d_o !== last_d) begin
        failures++;
        $display("FAIL gap_hold got addr=%0d d=%h want addr=%0d d=%h",
                 mem2_addr_o, mem2_d_o, last_addr, last_d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n, input logic relu, input logic [4:0] sh);
    start_i     = 1'b1;
    num_words_i = AW'(n);
    relu_en_i   = relu;
    shift_i     = sh;
    tick();
    start_i  = 1'b0;
    nxt_addr = '0;
  endtask

  task automatic send(input logic [PSW-1:0] d, input logic [DSW-1:0] exp_d);
    int   t;
    exp_t e;
    psum_valid_i = 1'b1;
    psum_i       = d;
    t            = 0;
    while (ready_o !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL send_timeout ready=%b want 1", ready_o);
    end else begin
      e.addr = nxt_addr;
      e.data = exp_d;
      e.cyc  = cyc + 2;
      exp_q.push_back(e);
      nxt_addr++;
      tick();
    end
    psum_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (done_o !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (done_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_timeout done=%b want 1", name, done_o);
    end else begin
      checks++;
      if (cyc != last_wr_cyc + 1) begin
        failures++;
        $display("FAIL %s_done_cycle got %0d want %0d", name, cyc, last_wr_cyc + 1);
      end
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        failures++;
        $display("FAIL %s_done_pulse done=%b busy=%b want 0 0", name, done_o, busy_o);
      end
    end
  endtask

  function automatic logic [PSW-1:0] mk3(input int a, input int b, input int c);
    logic [PSW-1:0] v;
    v = '0;
    v[PSW-1 -: PW]        = a;
    v[PSW-1-PW -: PW]     = b;
    v[PSW-1-2*PW -: PW]   = c;
    return v;
  endfunction

  function automatic logic [PSW-1:0] mk_all(input int x);
    logic [PSW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*PW +: PW] = x;
    return v;
  endfunction

  initial begin
    logic [7:0] bv;
    int         wr0;
    int         bc;
    int         dc;

    repeat (3) @(negedge clk);
    checks++;
    if ({ready_o, busy_o, done_o, mem2_ce_o, mem2_we_o} !== 5'b0 || mem2_addr_o !== '0 || mem2_d_o !== '0) begin
      failures++;
      $display("FAIL reset_state rdy=%b busy=%b done=%b ce=%b we=%b addr=%0d d=%h want all 0",
               ready_o, busy_o, done_o, mem2_ce_o, mem2_we_o, mem2_addr_o, mem2_d_o);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // three back-to-back beats, all lanes 5
    start_job(3, 1'b1, 5'd0);
    for (int k = 0; k < 3; k++) send(mk_all(5), {LANES{8'h05}});
    wait_done("basic");

    // rounding shift with ReLU clamp
    start_job(1, 1'b1, 5'd4);
    send(mk3(24, -100, 100000), {8'h02, 8'h00, 8'hFF, {11{8'h00}}});
    wait_done("relu_shift");

    // signed clamp
    start_job(1, 1'b0, 5'd0);
    send(mk3(200, -200, -5), {8'h7F, 8'h80, 8'hFB, {11{8'h00}}});
    wait_done("signed");

    // full-depth job with valid toggling, plus an extra beat after the last
    wr0 = wr_count;
    start_job(896, 1'b1, 5'd0);
    for (int k = 0; k < 896; k++) begin
      bv = 8'(k & 127);
      send(mk_all(k & 127), {LANES{bv}});
      if (k < 895) tick();
    end
    checks++;
    if (ready_o !== 1'b0) begin
      failures++;
      $display("FAIL full_ready_after_last got %b want 0", ready_o);
    end
    psum_valid_i = 1'b1;
    psum_i       = mk_all(99);
    tick();
    wait_done("full");
    psum_valid_i = 1'b0;
    checks++;
    if (wr_count - wr0 != 896 || last_addr !== AW'(895)) begin
      failures++;
      $display("FAIL full_count got writes=%0d last_addr=%0d want 896 895", wr_count - wr0, last_addr);
    end

    // zero-length job
    wr0 = wr_count;
    start_job(0, 1'b1, 5'd0);
    bc = 0;
    dc = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      else #4;
      if (busy_o === 1'b1) bc++;
      if (done_o === 1'b1) dc++;
    end
    checks++;
    if (bc != 1 || dc != 1 || wr_count != wr0) begin
      failures++;
      $display("FAIL zero_job got busy=%0d done=%0d writes=%0d want 1 1 0", bc, dc, wr_count - wr0);
    end

    // reset in the middle of a job
    tick();
    start_job(10, 1'b1, 5'd0);
    for (int k = 0; k < 5; k++) send(mk_all(7), {LANES{8'h07}});
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({ready_o, busy_o, done_o, mem2_ce_o, mem2_we_o} !== 5'b0 || mem2_addr_o !== '0 || mem2_d_o !== '0) begin
      failures++;
      $display("FAIL midjob_reset rdy=%b busy=%b done=%b ce=%b we=%b addr=%0d d=%h want all 0",
               ready_o, busy_o, done_o, mem2_ce_o, mem2_we_o, mem2_addr_o, mem2_d_o);
    end
    tick();
    tick();
    rst_n = 1'b1;
    wr0 = wr_count;
    repeat (5) tick();
    checks++;
    if (wr_count != wr0) begin
      failures++;
      $display("FAIL post_reset_writes got %0d want 0", wr_count - wr0);
    end
    start_job(2, 1'b1, 5'd0);
    send(mk3(200, -200, -5), {8'hC8, 8'h00, 8'h00, {11{8'h00}}});
    send(mk3(1, 2, 3), {8'h01, 8'h02, 8'h03, {11{8'h00}}});
    wait_done("restart");

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected got %0d want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
